// File: rtl/nor_tree_pipe.sv
`default_nettype none
// ============================================================================
// nor_tree_pipe : pipelined FANIN-ary OR/NOR reduction with valid/ready stall
// Revision 1.0
// ============================================================================
module nor_tree_pipe #(
  parameter int WIDTH  = 9,
  parameter int FANIN  = 3,
  parameter int INVERT = 1
) (
  input  logic             ck,
  input  logic             rst,
  input  logic [WIDTH-1:0] i,
  input  logic [WIDTH-1:0] msk,
  input  logic             i_valid,
  output logic             i_ready,
  output logic             nq,
  output logic             nq_valid,
  input  logic             nq_ready
);

  function automatic int n_at(input int k);
    int n;
    n = WIDTH;
    for (int j = 0; j < k; j++) n = (n + FANIN - 1) / FANIN;
    return n;
  endfunction

  function automatic int levels_f();
    int n;
    int lv;
    n  = WIDTH;
    lv = 0;
    while (lv == 0 || n > 1) begin
      n  = (n + FANIN - 1) / FANIN;
      lv = lv + 1;
    end
    return lv;
  endfunction

  // Bit offset of level k in the concatenation {level L-1, ..., level 1, leaves}
  function automatic int pos_at(input int k);
    int s;
    s = 0;
    for (int j = 0; j < k; j++) s = s + n_at(j);
    return s;
  endfunction

  localparam int LEVELS = levels_f();
  localparam int TOT    = pos_at(LEVELS + 1) - WIDTH;
  localparam int CHW    = pos_at(LEVELS);

  logic [TOT-1:0]    data_q, data_d;
  logic [LEVELS-1:0] v_q, v_d;
  logic [TOT-1:0]    w_nodes;
  logic [WIDTH-1:0]  w_leaves;
  logic [CHW-1:0]    w_chain;
  logic              w_adv;

  assign w_leaves = i & ~msk;

  if (LEVELS == 1) begin : g_chain_leaf
    assign w_chain = w_leaves;
  end else begin : g_chain_tree
    assign w_chain = {data_q[TOT-2:0], w_leaves};
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    localparam int NP  = n_at(k - 1);
    localparam int NK  = n_at(k);
    localparam int SRC = pos_at(k - 1);
    localparam int DST = pos_at(k) - WIDTH;
    for (genvar m = 0; m < NK; m++) begin : g_node
      // The last node of a level may see fewer than FANIN inputs; missing ones act as 0
      localparam int LO  = m * FANIN;
      localparam int CNT = (LO + FANIN > NP) ? (NP - LO) : FANIN;
      assign w_nodes[DST+m] = |w_chain[SRC+LO +: CNT];
    end
  end

  assign w_adv    = ~v_q[LEVELS-1] | nq_ready;
  assign i_ready  = w_adv;
  assign nq_valid = v_q[LEVELS-1];

  if (INVERT != 0) begin : g_inv
    assign nq = ~data_q[TOT-1];
  end else begin : g_pass
    assign nq = data_q[TOT-1];
  end

  always_comb begin
    data_d = data_q;
    v_d    = v_q;
    if (w_adv) begin
      data_d = w_nodes;
      v_d[0] = i_valid;
      for (int k = 1; k < LEVELS; k++) v_d[k] = v_q[k-1];
    end
  end

  always_ff @(posedge ck) begin
    if (rst) begin
      data_q <= '0;
      v_q    <= '0;
    end else begin
      data_q <= data_d;
      v_q    <= v_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nor_tree_pipe.sv
`default_nettype none
// ============================================================================
// tb_nor_tree_pipe : directed and swept checks of nor_tree_pipe configurations
// Revision 1.0
// ============================================================================
module tb_nor_tree_pipe;

  logic        ck = 1'b0;
  logic        rst;
  logic [26:0] i_bus;
  logic [26:0] msk_bus;
  logic        i_valid;
  logic        nq_ready;
  logic [4:0]  nq_w;
  logic [4:0]  nqv_w;
  logic [4:0]  ir_w;

  int errors = 0;
  int checks = 0;

  always #5 ck = ~ck;

  // d0: W9 F3 NOR, d1: W1 NOR, d2: W27 F3 NOR, d3: W10 F4 NOR, d4: W9 F3 OR
  nor_tree_pipe #(.WIDTH(9), .FANIN(3), .INVERT(1)) u_d0 (
    .ck(ck), .rst(rst), .i(i_bus[8:0]), .msk(msk_bus[8:0]), .i_valid(i_valid),
    .i_ready(ir_w[0]), .nq(nq_w[0]), .nq_valid(nqv_w[0]), .nq_ready(nq_ready));
  nor_tree_pipe #(.WIDTH(1), .FANIN(3), .INVERT(1)) u_d1 (
    .ck(ck), .rst(rst), .i(i_bus[0:0]), .msk(msk_bus[0:0]), .i_valid(i_valid),
    .i_ready(ir_w[1]), .nq(nq_w[1]), .nq_valid(nqv_w[1]), .nq_ready(nq_ready));
  nor_tree_pipe #(.WIDTH(27), .FANIN(3), .INVERT(1)) u_d2 (
    .ck(ck), .rst(rst), .i(i_bus), .msk(msk_bus), .i_valid(i_valid),
    .i_ready(ir_w[2]), .nq(nq_w[2]), .nq_valid(nqv_w[2]), .nq_ready(nq_ready));
  nor_tree_pipe #(.WIDTH(10), .FANIN(4), .INVERT(1)) u_d3 (
    .ck(ck), .rst(rst), .i(i_bus[9:0]), .msk(msk_bus[9:0]), .i_valid(i_valid),
    .i_ready(ir_w[3]), .nq(nq_w[3]), .nq_valid(nqv_w[3]), .nq_ready(nq_ready));
  nor_tree_pipe #(.WIDTH(9), .FANIN(3), .INVERT(0)) u_d4 (
    .ck(ck), .rst(rst), .i(i_bus[8:0]), .msk(msk_bus[8:0]), .i_valid(i_valid),
    .i_ready(ir_w[4]), .nq(nq_w[4]), .nq_valid(nqv_w[4]), .nq_ready(nq_ready));

  function automatic int lev(input int d);
    case (d)
      0: return 2;
      1: return 1;
      2: return 3;
      3: return 2;
      default: return 2;
    endcase
  endfunction

  function automatic int wid(input int d);
    case (d)
      0: return 9;
      1: return 1;
      2: return 27;
      3: return 10;
      default: return 9;
    endcase
  endfunction

  function automatic logic ref_nq(input int d, input logic [26:0] iv, input logic [26:0] mv);
    logic any;
    any = 1'b0;
    for (int b = 0; b < 27; b++) if (b < wid(d)) any = any | (iv[b] & ~mv[b]);
    return (d != 4) ? ~any : any;
  endfunction

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; nq_ready = 1'b1; i_bus = '0; msk_bus = '0;
    tick(); tick(); #1;
    checks++; if (nqv_w[0] !== 1'b0) begin errors++; $display("FAIL reset_nq_valid got=%b exp=0", nqv_w[0]); end
    checks++; if (ir_w[0] !== 1'b1)  begin errors++; $display("FAIL reset_i_ready got=%b exp=1", ir_w[0]); end
    checks++; if (nq_w[0] !== 1'b1)  begin errors++; $display("FAIL reset_nq got=%b exp=1", nq_w[0]); end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick(); #1;
      checks++; if (nqv_w[0] !== 1'b0) begin errors++; $display("FAIL idle_nq_valid c=%0d got=%b exp=0", c, nqv_w[0]); end
    end
  endtask

  task automatic test_latency_function();
    msk_bus = '0; nq_ready = 1'b1; i_valid = 1'b1; i_bus = 27'h000; #1;
    checks++; if (ir_w[0] !== 1'b1) begin errors++; $display("FAIL t2_ready got=%b exp=1", ir_w[0]); end
    tick(); #1;
    checks++; if (nqv_w[0] !== 1'b0) begin errors++; $display("FAIL t2_early_valid got=%b exp=0", nqv_w[0]); end
    i_bus = 27'h100;
    tick(); #1;
    checks++; if (nqv_w[0] !== 1'b1 || nq_w[0] !== 1'b1) begin errors++; $display("FAIL t2_res0 got=%b/%b exp=1/1", nqv_w[0], nq_w[0]); end
    i_bus = 27'h001;
    tick(); #1;
    checks++; if (nqv_w[0] !== 1'b1 || nq_w[0] !== 1'b0) begin errors++; $display("FAIL t2_res1 got=%b/%b exp=1/0", nqv_w[0], nq_w[0]); end
    i_valid = 1'b0;
    tick(); #1;
    checks++; if (nqv_w[0] !== 1'b1 || nq_w[0] !== 1'b0) begin errors++; $display("FAIL t2_res2 got=%b/%b exp=1/0", nqv_w[0], nq_w[0]); end
    tick(); #1;
    checks++; if (nqv_w[0] !== 1'b0) begin errors++; $display("FAIL t2_drained got=%b exp=0", nqv_w[0]); end
  endtask

  task automatic test_masking();
    nq_ready = 1'b1; i_valid = 1'b1; i_bus = 27'h1F0; msk_bus = 27'h1F0;
    tick();
    msk_bus = 27'h0F0;
    tick(); #1;
    checks++; if (nqv_w[0] !== 1'b1 || nq_w[0] !== 1'b1) begin errors++; $display("FAIL t3_full_mask got=%b/%b exp=1/1", nqv_w[0], nq_w[0]); end
    i_valid = 1'b0;
    tick(); #1;
    checks++; if (nqv_w[0] !== 1'b1 || nq_w[0] !== 1'b0) begin errors++; $display("FAIL t3_part_mask got=%b/%b exp=1/0", nqv_w[0], nq_w[0]); end
    tick();
  endtask

  task automatic test_back_pressure();
    logic [26:0] ops [4];
    logic        exp [4];
    int   in_idx, out_idx, stall;
    logic prev_stall, prev_nq;
    ops[0] = 27'h000; ops[1] = 27'h004; ops[2] = 27'h000; ops[3] = 27'h080;
    exp[0] = 1'b1;    exp[1] = 1'b0;    exp[2] = 1'b1;    exp[3] = 1'b0;
    in_idx = 0; out_idx = 0; stall = -1; prev_stall = 1'b0; prev_nq = 1'b0;
    msk_bus = '0;
    for (int c = 0; c < 30; c++) begin
      if (stall < 0 && nqv_w[0] === 1'b1) stall = 3;
      nq_ready = (stall > 0) ? 1'b0 : 1'b1;
      i_valid  = (in_idx < 4);
      i_bus    = (in_idx < 4) ? ops[in_idx] : 27'h0;
      #1;
      if (prev_stall) begin
        checks++;
        if (nqv_w[0] !== 1'b1 || nq_w[0] !== prev_nq) begin
          errors++; $display("FAIL t4_hold c=%0d got=%b/%b exp=1/%b", c, nqv_w[0], nq_w[0], prev_nq);
        end
      end
      if (stall > 0) begin
        checks++; if (ir_w[0] !== 1'b0) begin errors++; $display("FAIL t4_ready_stall c=%0d got=%b exp=0", c, ir_w[0]); end
      end
      if (nqv_w[0] === 1'b1 && nq_ready) begin
        checks++;
        if (out_idx >= 4) begin
          errors++; $display("FAIL t4_duplicate c=%0d got=extra exp=none", c);
        end else begin
          if (nq_w[0] !== exp[out_idx]) begin errors++; $display("FAIL t4_order idx=%0d got=%b exp=%b", out_idx, nq_w[0], exp[out_idx]); end
          out_idx++;
        end
      end
      prev_stall = (nqv_w[0] === 1'b1) && !nq_ready;
      prev_nq    = nq_w[0];
      if (i_valid && ir_w[0] === 1'b1) in_idx++;
      if (stall > 0) stall--;
      tick();
    end
    checks++; if (out_idx != 4) begin errors++; $display("FAIL t4_count got=%0d exp=4", out_idx); end
    checks++; if (stall != 0)   begin errors++; $display("FAIL t4_stall_seen got=%0d exp=0", stall); end
  endtask

  task automatic test_reset_flush();
    nq_ready = 1'b1; msk_bus = '0; i_valid = 1'b1; i_bus = 27'h000;
    tick();
    i_bus = 27'h002; rst = 1'b1;
    tick(); #1;
    checks++; if (nqv_w[0] !== 1'b0) begin errors++; $display("FAIL t5_flush got=%b exp=0", nqv_w[0]); end
    rst = 1'b0; i_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick(); #1;
      checks++; if (nqv_w[0] !== 1'b0) begin errors++; $display("FAIL t5_no_emerge c=%0d got=%b exp=0", c, nqv_w[0]); end
    end
  endtask

  task automatic test_sweep_latency();
    rst = 1'b1; i_valid = 1'b0; nq_ready = 1'b1; i_bus = '0; msk_bus = '0;
    tick();
    rst = 1'b0; i_valid = 1'b1; i_bus = 27'h1;
    tick();
    i_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #1;
      for (int d = 0; d < 5; d++) begin
        checks++;
        if (nqv_w[d] !== (j == lev(d) - 1)) begin
          errors++; $display("FAIL lat d=%0d j=%0d got=%b exp=%b", d, j, nqv_w[d], (j == lev(d) - 1));
        end
        if (j == lev(d) - 1) begin
          checks++;
          if (nq_w[d] !== ((d == 4) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL lat_val d=%0d got=%b", d, nq_w[d]); end
        end
      end
      tick();
    end
  endtask

  logic exp_buf [5][64];
  int   wr_p [5];
  int   rd_p [5];
  logic pst [5];
  logic pnq [5];

  task automatic sweep_cycle();
    #1;
    for (int d = 0; d < 5; d++) begin
      if (pst[d]) begin
        checks++;
        if (nqv_w[d] !== 1'b1 || nq_w[d] !== pnq[d]) begin
          errors++; $display("FAIL sw_hold d=%0d got=%b/%b exp=1/%b", d, nqv_w[d], nq_w[d], pnq[d]);
        end
      end
      checks++;
      if (ir_w[d] !== (~nqv_w[d] | nq_ready)) begin
        errors++; $display("FAIL sw_ready d=%0d got=%b exp=%b", d, ir_w[d], ~nqv_w[d] | nq_ready);
      end
      if (nqv_w[d] === 1'b1 && nq_ready) begin
        checks++;
        if (rd_p[d] == wr_p[d]) begin
          errors++; $display("FAIL sw_extra d=%0d got=result exp=none", d);
        end else begin
          if (nq_w[d] !== exp_buf[d][rd_p[d] % 64]) begin
            errors++; $display("FAIL sw_data d=%0d n=%0d got=%b exp=%b", d, rd_p[d], nq_w[d], exp_buf[d][rd_p[d] % 64]);
          end
          rd_p[d]++;
        end
      end
      pst[d] = (nqv_w[d] === 1'b1) && !nq_ready;
      pnq[d] = nq_w[d];
      if (i_valid && ir_w[d] === 1'b1) begin
        exp_buf[d][wr_p[d] % 64] = ref_nq(d, i_bus, msk_bus);
        wr_p[d]++;
      end
    end
    tick();
  endtask

  task automatic test_random_sweep();
    rst = 1'b1; i_valid = 1'b0; nq_ready = 1'b1;
    tick();
    rst = 1'b0;
    for (int d = 0; d < 5; d++) begin wr_p[d] = 0; rd_p[d] = 0; pst[d] = 1'b0; pnq[d] = 1'b0; end
    for (int n = 0; n < 1000; n++) begin
      case ($urandom_range(0, 3))
        0:       i_bus = 27'(1) << $urandom_range(0, 26);
        1:       i_bus = '0;
        default: i_bus = 27'($urandom);
      endcase
      msk_bus  = ($urandom_range(0, 7) == 0) ? '1 : 27'($urandom & $urandom);
      i_valid  = ($urandom_range(0, 3) != 0);
      nq_ready = ($urandom_range(0, 3) != 0);
      sweep_cycle();
    end
    i_valid = 1'b0; nq_ready = 1'b1;
    for (int n = 0; n < 6; n++) sweep_cycle();
    for (int d = 0; d < 5; d++) begin
      checks++;
      if (rd_p[d] != wr_p[d]) begin errors++; $display("FAIL sw_lost d=%0d got=%0d exp=%0d", d, rd_p[d], wr_p[d]); end
    end
  endtask

  initial begin
    rst = 1'b1; i_valid = 1'b0; nq_ready = 1'b1; i_bus = '0; msk_bus = '0;
    test_reset();
    test_latency_function();
    test_masking();
    test_back_pressure();
    test_reset_flush();
    test_sweep_latency();
    test_random_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
